score_event_encoder: RTL

//  Producer side of the score interface that feeds Seven_Seg_Display-style counters: turns game scoring events
//  (N points at once) into a train of score_signal edges. Each edge (rising OR falling) is worth exactly one point.

---
 rtl/score_event_encoder_if.sv | 26 ++
 rtl/score_event_encoder.sv | 94 +++++++++
 2 files changed

// File: rtl/score_event_encoder_if.sv
// Score event bundle: hit strobes in, paced score edges and status out.
interface score_event_encoder_if #(
  parameter int PEND_W = 8
);
  logic              hit_valid;
  logic [3:0]        hit_points;
  logic              game_end;
  logic              score_signal;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic [15:0]       total_bcd;
  logic              drained;

  modport master (
    output hit_valid, hit_points, game_end,
    input  score_signal, busy, pending,
    input  overflow, total_bcd, drained
  );

  modport slave (
    input  hit_valid, hit_points, game_end,
    output score_signal, busy, pending,
    output overflow, total_bcd, drained
  );
endinterface

// File: rtl/score_event_encoder.sv
// Turns multi-point hits into a paced train of score edges,
// one point per edge, with a BCD mirror of the emitted total.
module score_event_encoder #(
  parameter int GAP_CYCLES = 4,
  parameter int PEND_W     = 8
) (
  input logic                clk,
  input logic                rst,
  score_event_encoder_if.slave bus
);
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     gap_cnt;
  logic [PEND_W-1:0] pending;
  logic              sig;
  logic              ovf;
  logic [15:0]       bcd;

  logic              acc;
  logic              emit;
  logic [PEND_W:0]   sum;
  logic [PEND_W:0]   add;
  logic [15:0]       bcd_inc;
  logic              carry;

  always_comb begin
    acc  = bus.hit_valid && !bus.game_end;
    emit = (state == IDLE) && (pending != '0);
    add  = acc ? {{(PEND_W-3){1'b0}}, bus.hit_points} : '0;
    sum  = {1'b0, pending} + add - {{PEND_W{1'b0}}, emit};
  end

  // Ripple the +1 through the digits; a 9 rolls to 0 and carries on.
  always_comb begin
    bcd_inc = bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i*4 +: 4] == 4'd9) begin
          bcd_inc[i*4 +: 4] = 4'd0;
        end else begin
          bcd_inc[i*4 +: 4] = bcd[i*4 +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      pending <= '0;
      sig     <= 1'b0;
      ovf     <= 1'b0;
      bcd     <= '0;
    end else begin
      // sum never exceeds twice the max, so the top bit flags clipping
      if (sum[PEND_W]) begin
        pending <= '1;
        ovf     <= 1'b1;
      end else begin
        pending <= sum[PEND_W-1:0];
      end
      unique case (state)
        IDLE: begin
          if (emit) begin
            sig <= ~sig;
            bcd <= bcd_inc;
            if (GAP_CYCLES > 1) begin
              gap_cnt <= CW'(GAP_CYCLES - 1);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == CW'(1)) state <= IDLE;
        end
      endcase
    end
  end

  assign bus.score_signal = sig;
  assign bus.pending      = pending;
  assign bus.overflow     = ovf;
  assign bus.total_bcd    = bcd;
  assign bus.busy         = (pending != '0) || (state == GAP);
  assign bus.drained      = bus.game_end && (pending == '0) &&
                            (state == IDLE);
endmodule
